// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the clear/run state encoding and the default sizing constants
// used when the register file is instantiated without overrides.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (clears all bits)
//   run_i            block is in normal operation; sets/clears and lookups
//                    are suppressed while the clear engine runs
//   we_i, wr_ptr_i   writeback, clears the destination bit
//   set_i, set_ptr_i decode issue, sets the destination bit
//   rs_ptr_i         NRD packed read pointers
//   busy_o           NRD busy flags, masked by a same-cycle writeback
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic            we_i,
  input  logic [AW-1:0]   wr_ptr_i,
  input  logic            set_i,
  input  logic [AW-1:0]   set_ptr_i,
  input  logic [NRD*AW-1:0] rs_ptr_i,
  output logic [NRD-1:0]  busy_o
);

  logic [NREGS-1:0] sb_q, sb_d;
  logic             wr_ok, set_ok;

  assign wr_ok  = run_i & we_i  & ~((ZERO_REG != 0) && (wr_ptr_i  == '0));
  assign set_ok = run_i & set_i & ~((ZERO_REG != 0) && (set_ptr_i == '0));

  // Clear first, then set: a same-register set in the same cycle wins.
  always_comb begin
    sb_d = sb_q;
    if (wr_ok)  sb_d[wr_ptr_i]  = 1'b0;
    if (set_ok) sb_d[set_ptr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  // Busy seen by a reader is the stored bit minus a write retiring right now;
  // a same-cycle set only shows up next cycle.
  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [AW-1:0] ptr;
    assign ptr       = rs_ptr_i[k*AW +: AW];
    assign busy_o[k] = run_i & sb_q[ptr] & ~(wr_ok && (wr_ptr_i == ptr));
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with combinational write bypass,
// pending-write scoreboard and a sequential post-reset clear engine.
// Ports:
//   i_CLK, i_RST        clock, synchronous active-high reset
//   o_READY             high once every register has been zeroed
//   i_WE/i_RD_PTR/i_RD  writeback port (rising-edge write)
//   i_RS_PTR, o_RS      NRD packed read pointers / read data (combinational)
//   o_RS_BUSY           NRD pending-write flags for the read sources
//   i_SB_SET/i_SB_PTR   mark a destination busy at decode issue
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  output logic               o_READY,
  input  logic               i_WE,
  input  logic [AW-1:0]      i_RD_PTR,
  input  logic [XLEN-1:0]    i_RD,
  input  logic [NRD*AW-1:0]  i_RS_PTR,
  output logic [NRD*XLEN-1:0] o_RS,
  output logic [NRD-1:0]     o_RS_BUSY,
  input  logic               i_SB_SET,
  input  logic [AW-1:0]      i_SB_PTR
);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            clr_we;
  logic            run;
  logic            wr_ok;
  logic [XLEN-1:0] regs_q [NREGS];

  assign run     = (state_q == ST_RUN);
  assign o_READY = run;
  assign wr_ok   = run & i_WE & ~((ZERO_REG != 0) && (i_RD_PTR == '0));

  // Clear engine: walk cnt over every register, zeroing one per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array has no reset; the clear engine provides the zero contents.
  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      if (clr_we)     regs_q[cnt_q]    <= '0;
      else if (wr_ok) regs_q[i_RD_PTR] <= i_RD;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ptr;
    logic [XLEN-1:0] rdata;
    assign ptr = i_RS_PTR[k*AW +: AW];
    always_comb begin
      rdata = regs_q[ptr];
      if (!run)                                     rdata = '0;
      else if ((ZERO_REG != 0) && (ptr == '0))      rdata = '0;
      else if (wr_ok && (i_RD_PTR == ptr))          rdata = i_RD;
    end
    assign o_RS[k*XLEN +: XLEN] = rdata;
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i     (i_CLK),
    .rst_i     (i_RST),
    .run_i     (run),
    .we_i      (i_WE),
    .wr_ptr_i  (i_RD_PTR),
    .set_i     (i_SB_SET),
    .set_ptr_i (i_SB_PTR),
    .rs_ptr_i  (i_RS_PTR),
    .busy_o    (o_RS_BUSY)
  );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int NREGS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst, we, sb_set, ready;
  logic [4:0]  rd_ptr, sb_ptr;
  logic [31:0] rd;
  logic [9:0]  rs_ptr;
  logic [63:0] rs;
  logic [1:0]  busy;

  // 64-bit, 16-register, 3-port, r0-writable instance
  logic         we2, sb_set2, ready2;
  logic [3:0]   rd_ptr2, sb_ptr2;
  logic [63:0]  rd2;
  logic [11:0]  rs_ptr2;
  logic [191:0] rs2;
  logic [2:0]   busy2;

  int checks = 0;
  int failures = 0;

  regfile_mp dut (
    .i_CLK(clk), .i_RST(rst), .o_READY(ready),
    .i_WE(we), .i_RD_PTR(rd_ptr), .i_RD(rd),
    .i_RS_PTR(rs_ptr), .o_RS(rs), .o_RS_BUSY(busy),
    .i_SB_SET(sb_set), .i_SB_PTR(sb_ptr)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) dut2 (
    .i_CLK(clk), .i_RST(rst), .o_READY(ready2),
    .i_WE(we2), .i_RD_PTR(rd_ptr2), .i_RD(rd2),
    .i_RS_PTR(rs_ptr2), .o_RS(rs2), .o_RS_BUSY(busy2),
    .i_SB_SET(sb_set2), .i_SB_PTR(sb_ptr2)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the default instance ----------------
  logic [31:0] m_regs [NREGS];
  bit          m_sb   [NREGS];
  int          clear_left = 0;  // edges still needed before the file is usable
  bit          m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid    = 1;
      clear_left = NREGS;
      foreach (m_sb[i]) m_sb[i] = 0;
    end else if (m_valid) begin
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0) foreach (m_regs[i]) m_regs[i] = '0;
      end else begin
        if (we && rd_ptr != 0) begin
          m_regs[rd_ptr] = rd;
          m_sb[rd_ptr]   = 0;
        end
        if (sb_set && sb_ptr != 0) m_sb[sb_ptr] = 1;
      end
    end
  end

  function automatic logic [31:0] exp_rs(input int k);
    logic [4:0] p;
    p = rs_ptr[k*5 +: 5];
    if (clear_left != 0 || p == 0) return '0;
    if (we && rd_ptr == p) return rd;
    return m_regs[p];
  endfunction

  function automatic logic exp_busy(input int k);
    logic [4:0] p;
    p = rs_ptr[k*5 +: 5];
    if (clear_left != 0 || p == 0) return 1'b0;
    return m_sb[p] && !(we && rd_ptr == p);
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_ready", {63'd0, ready}, {63'd0, clear_left == 0});
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_rs%0d", k), {32'd0, rs[k*32 +: 32]}, {32'd0, exp_rs(k)});
        chk($sformatf("model_busy%0d", k), {63'd0, busy[k]}, {63'd0, exp_busy(k)});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    for (int i = 0; i < 100 && !ready; i++) tick();
    @(negedge clk);
    chk("wait_ready", {63'd0, ready}, 64'd1);
  endtask

  function automatic logic [4:0] rnd_ptr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1; we = 0; sb_set = 0; rd_ptr = 0; sb_ptr = 0; rd = 0; rs_ptr = 0;
    we2 = 0; sb_set2 = 0; rd_ptr2 = 0; sb_ptr2 = 0; rd2 = 0; rs_ptr2 = 0;
    repeat (3) tick();
    rst = 0;
    wait_ready();

    // garbage preload
    repeat (40) begin
      we = 1; rd_ptr = 5'($urandom); rd = $urandom;
      sb_set = 1; sb_ptr = 5'($urandom);
      tick();
    end
    we = 0; sb_set = 0;

    // reset pulse and timed clear, with a write attempt during clear
    rst = 1;
    repeat (3) tick();
    rst = 0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) begin we = 1; rd_ptr = 5'd3; rd = 32'hAAAA_5555; sb_set = 1; sb_ptr = 5'd3; end
      if (i == 11) begin we = 0; sb_set = 0; end
      tick();
      @(negedge clk);
      chk("ready_timing", {63'd0, ready}, {63'd0, i == 32});
      chk("ready2_timing", {63'd0, ready2}, {63'd0, i >= 16});
    end

    // every register reads zero, nothing busy
    for (int r = 0; r < 32; r += 2) begin
      rs_ptr = {5'(r + 1), 5'(r)};
      @(negedge clk);
      chk("cleared_rd", rs, 64'd0);
      chk("cleared_busy", {62'd0, busy}, 64'd0);
      tick();
    end
    rs_ptr = {5'd0, 5'd3};
    @(negedge clk);
    chk("clear_ignores_we", {32'd0, rs[31:0]}, 64'd0);
    tick();

    // write then read: bypass, then array
    we = 1; rd_ptr = 5'd5; rd = 32'hDEAD_BEEF; rs_ptr = {5'd0, 5'd5};
    @(negedge clk);
    chk("bypass_r5", {32'd0, rs[31:0]}, 64'hDEAD_BEEF);
    tick();
    we = 0; rs_ptr = {5'd5, 5'd0};
    @(negedge clk);
    chk("array_r5", {32'd0, rs[63:32]}, 64'hDEAD_BEEF);
    tick();

    // zero register
    we = 1; rd_ptr = 5'd0; rd = 32'h1234_5678; sb_set = 1; sb_ptr = 5'd0; rs_ptr = 10'd0;
    @(negedge clk);
    chk("r0_bypass", rs, 64'd0);
    tick();
    we = 0; sb_set = 0;
    @(negedge clk);
    chk("r0_read", rs, 64'd0);
    chk("r0_busy", {62'd0, busy}, 64'd0);
    tick();

    // scoreboard
    sb_set = 1; sb_ptr = 5'd7; rs_ptr = {5'd7, 5'd7};
    @(negedge clk);
    chk("sb_set_same_cycle", {62'd0, busy}, 64'd0);
    tick();
    sb_set = 0;
    @(negedge clk);
    chk("sb_set_next", {62'd0, busy}, 64'd3);
    tick();
    we = 1; rd_ptr = 5'd7; rd = 32'h0000_0077;
    @(negedge clk);
    chk("sb_wr_masked", {62'd0, busy}, 64'd0);
    chk("sb_wr_bypass", {32'd0, rs[63:32]}, 64'h77);
    tick();
    we = 0;
    @(negedge clk);
    chk("sb_after_wr", {62'd0, busy}, 64'd0);
    tick();
    we = 1; rd_ptr = 5'd7; rd = 32'h0000_0078; sb_set = 1; sb_ptr = 5'd7;
    tick();
    we = 0; sb_set = 0;
    @(negedge clk);
    chk("sb_set_wins", {62'd0, busy}, 64'd3);
    tick();

    // parametrised instance: r0 writable on all three ports
    we2 = 1; rd_ptr2 = 4'd0; rd2 = 64'hFFFF_0000_FFFF_0000; rs_ptr2 = 12'd0;
    @(negedge clk);
    chk("p2_bypass0", rs2[63:0],    64'hFFFF_0000_FFFF_0000);
    chk("p2_bypass1", rs2[127:64],  64'hFFFF_0000_FFFF_0000);
    chk("p2_bypass2", rs2[191:128], 64'hFFFF_0000_FFFF_0000);
    tick();
    we2 = 0; sb_set2 = 1; sb_ptr2 = 4'd0;
    @(negedge clk);
    chk("p2_array0", rs2[63:0],    64'hFFFF_0000_FFFF_0000);
    chk("p2_array1", rs2[127:64],  64'hFFFF_0000_FFFF_0000);
    chk("p2_array2", rs2[191:128], 64'hFFFF_0000_FFFF_0000);
    tick();
    sb_set2 = 0;
    @(negedge clk);
    chk("p2_r0_busy", {61'd0, busy2}, 64'd7);
    tick();

    // randomized traffic with occasional reset
    repeat (3000) begin
      rst    = ($urandom_range(0, 399) == 0);
      we     = $urandom_range(0, 1) == 1;
      rd_ptr = rnd_ptr();
      rd     = $urandom;
      sb_set = $urandom_range(0, 2) == 0;
      sb_ptr = rnd_ptr();
      rs_ptr = {($urandom_range(0, 3) == 0) ? rd_ptr : rnd_ptr(),
                ($urandom_range(0, 3) == 0) ? rd_ptr : rnd_ptr()};
      tick();
    end
    rst = 0; we = 0; sb_set = 0;
    wait_ready();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
